cpu_run_controller: RTL and testbench

Run sequencer for `cpu_pipelined`: streams a program into instruction memory while the core is held in reset, releases the core, counts execution cycles until `end_program`, lets the pipeline drain a fixed number of cycles, then freezes the core and reports completion. It sits between a host/loader interface and the core's `reset`, clock-enable and `imem` write port. It replaces hand-written memory preloads and drain loops with synthesizable hardware.

---
 rtl/cpu_run_controller.sv | 121 ++++++++++++
 tb/tb_cpu_run_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// Run sequencer for cpu_pipelined: loads imem with the core held in reset, runs it,
// counts RUN cycles, drains the pipeline after end_program, then freezes the core.
module cpu_run_controller #(
    parameter  int IMEM_DEPTH   = 64,
    parameter  int DRAIN_CYCLES = 5,
    parameter  int CYCLE_W      = 32,
    parameter  int MAX_CYCLES   = 0,
    localparam int AW           = $clog2(IMEM_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [31:0]        load_data,
    input  logic               load_last,
    input  logic               start,
    input  logic               clear,
    output logic               imem_we,
    output logic [AW-1:0]      imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               core_reset,
    output logic               core_run,
    input  logic               end_program,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CYCLE_W-1:0] cycle_count
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {S_LOAD, S_ARMED, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [AW:0]        r_wr_ptr;
    logic [DW-1:0]      r_drain_cnt;
    logic [CYCLE_W-1:0] r_cycle_count;
    logic               r_timeout;
    logic               r_core_reset;
    logic               r_running;
    logic               r_done;

    logic               w_hs;
    logic               w_last_addr;
    logic [CYCLE_W-1:0] w_cnt_inc;
    logic               w_max_hit;

    assign load_ready = (r_state == S_LOAD) && (r_wr_ptr < (AW+1)'(IMEM_DEPTH));
    // Gated by reset so the write strobe is dead while reset is held.
    assign w_hs       = reset && load_valid && load_ready;
    assign imem_we    = w_hs;
    assign imem_addr  = w_hs ? r_wr_ptr[AW-1:0] : '0;
    assign imem_wdata = w_hs ? load_data : '0;

    assign w_last_addr = (r_wr_ptr[AW-1:0] == AW'(IMEM_DEPTH - 1));
    assign w_cnt_inc   = (&r_cycle_count) ? r_cycle_count : r_cycle_count + 1'b1;
    assign w_max_hit   = (MAX_CYCLES != 0) && (w_cnt_inc == CYCLE_W'(MAX_CYCLES));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD: begin
                if (start)
                    w_next = S_RUN;
                else if (w_hs && (load_last || w_last_addr))
                    w_next = S_ARMED;
            end
            S_ARMED: if (start) w_next = S_RUN;
            S_RUN: begin
                if (end_program)
                    w_next = S_DRAIN;
                else if (w_max_hit)
                    w_next = S_DONE;
            end
            S_DRAIN: if (r_drain_cnt == DW'(1)) w_next = S_DONE;
            S_DONE:  if (clear) w_next = S_LOAD;
            default: w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_LOAD;
            r_wr_ptr      <= '0;
            r_drain_cnt   <= '0;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
            r_core_reset  <= 1'b1;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_hs)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_state == S_RUN) begin
                r_cycle_count <= w_cnt_inc;
                if (end_program)
                    r_drain_cnt <= DW'(DRAIN_CYCLES);
                else if (w_max_hit)
                    r_timeout <= 1'b1;
            end
            if (r_state == S_DRAIN)
                r_drain_cnt <= r_drain_cnt - DW'(1);
            if (r_state == S_DONE && clear) begin
                r_wr_ptr      <= '0;
                r_cycle_count <= '0;
                r_timeout     <= 1'b0;
            end
            // Outputs registered from the next state so they change with it.
            r_core_reset <= (w_next == S_LOAD) || (w_next == S_ARMED);
            r_running    <= (w_next == S_RUN) || (w_next == S_DRAIN);
            r_done       <= (w_next == S_DONE);
        end
    end

    assign core_reset  = r_core_reset;
    assign core_run    = r_running;
    assign busy        = r_running;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_count;
endmodule

// File: tb/tb_cpu_run_controller.sv
// Randomized bench for cpu_run_controller: instance A (depth 64, no timeout) and
// instance B (depth 4, MAX_CYCLES 20) share stimulus; the idle one is held in reset.
module tb_cpu_run_controller;
    localparam int DR = 5;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        lv, ll, st, clr, ep;
    logic [31:0] ld;
    logic        sel;

    logic        a_ready, a_we, a_creset, a_crun, a_busy, a_done, a_to;
    logic [5:0]  a_addr;
    logic [31:0] a_wdata, a_cnt;
    logic        b_ready, b_we, b_creset, b_crun, b_busy, b_done, b_to;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata, b_cnt;

    logic        cur_ready, cur_we, cur_creset, cur_crun, cur_busy, cur_done, cur_to;
    logic [5:0]  cur_addr;
    logic [31:0] cur_wdata, cur_cnt;

    int n_chk = 0;
    int n_err = 0;

    // model of the loader: still accepting words, and next write address
    bit m_loading;
    int m_ptr;
    int dep;
    int mx;
    logic [38:0] wq[$];
    logic [38:0] eq[$];
    logic [31:0] fixed_w[6] = '{32'h00002103, 32'h00408193, 32'hDEADBEEF,
                                32'h12345678, 32'hFFFFFFFF, 32'hCAFEF00D};

    always #5 clk = ~clk;

    cpu_run_controller u_a (
        .clk(clk), .reset(rst_a), .load_valid(lv), .load_ready(a_ready),
        .load_data(ld), .load_last(ll), .start(st), .clear(clr),
        .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
        .core_reset(a_creset), .core_run(a_crun), .end_program(ep),
        .busy(a_busy), .done(a_done), .timeout(a_to), .cycle_count(a_cnt)
    );

    cpu_run_controller #(.IMEM_DEPTH(4), .MAX_CYCLES(20)) u_b (
        .clk(clk), .reset(rst_b), .load_valid(lv), .load_ready(b_ready),
        .load_data(ld), .load_last(ll), .start(st), .clear(clr),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .core_reset(b_creset), .core_run(b_crun), .end_program(ep),
        .busy(b_busy), .done(b_done), .timeout(b_to), .cycle_count(b_cnt)
    );

    always_comb begin
        if (sel) begin
            cur_ready = b_ready; cur_we = b_we; cur_creset = b_creset; cur_crun = b_crun;
            cur_busy = b_busy; cur_done = b_done; cur_to = b_to;
            cur_addr = {4'd0, b_addr}; cur_wdata = b_wdata; cur_cnt = b_cnt;
        end else begin
            cur_ready = a_ready; cur_we = a_we; cur_creset = a_creset; cur_crun = a_crun;
            cur_busy = a_busy; cur_done = a_done; cur_to = a_to;
            cur_addr = a_addr; cur_wdata = a_wdata; cur_cnt = a_cnt;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (cur_we)
            wq.push_back({sel, cur_addr, cur_wdata});
        else
            chk("bus_idle_zero", {26'd0, cur_addr, cur_wdata}, 64'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rst(input logic v);
        if (sel) rst_b = v; else rst_a = v;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk(tag, {cur_creset, cur_crun, cur_busy, cur_done, cur_we, cur_ready, cur_to},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        chk({tag, "_cnt"}, cur_cnt, 0);
    endtask

    task automatic chk_writes();
        chk("n_writes", wq.size(), eq.size());
        for (int i = 0; i < wq.size() && i < eq.size(); i++)
            chk("write", wq[i], eq[i]);
        wq.delete();
        eq.delete();
    endtask

    task automatic send_words(input int n, input int last_at, input int start_at,
                              input bit gap, input bit fixed);
        bit exp_rdy;
        for (int i = 0; i < n; i++) begin
            if (gap && i == n / 2) begin
                lv = 1'b0;
                tick();
            end
            lv = 1'b1;
            ld = fixed ? fixed_w[i] : $urandom;
            ll = (i == last_at);
            st = (i == start_at);
            #1;
            exp_rdy = m_loading && (m_ptr < dep);
            chk("load_ready", cur_ready, exp_rdy);
            if (!exp_rdy) begin
                st = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk("stall_ready", {cur_ready, cur_creset}, 2'b01);
                end
                break;
            end
            eq.push_back({sel, 6'(m_ptr), ld});
            m_ptr++;
            if (ll || m_ptr == dep || st) m_loading = 1'b0;
            tick();
            st = 1'b0;
            ll = 1'b0;
        end
        lv = 1'b0;
        ll = 1'b0;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clear_out", {cur_done, cur_creset, cur_crun, cur_busy, cur_to, cur_ready}, 6'b010001);
        chk("clear_cnt", cur_cnt, 0);
        m_loading = 1'b1;
        m_ptr = 0;
    endtask

    // e: RUN cycle on which end_program rises (0 = never); rst_k: abort edge (-1 = none)
    task automatic run_prog(input int e, input bit do_start, input int rst_k);
        int  exp_done, exp_cnt, done_k, busy_n;
        bit  exp_to;
        if (e != 0 && (mx == 0 || e <= mx)) begin
            exp_done = e + DR; exp_cnt = e; exp_to = 1'b0;
        end else begin
            exp_done = mx; exp_cnt = mx; exp_to = 1'b1;
        end
        if (do_start) begin
            st = 1'b1;
            tick();
            st = 1'b0;
        end
        m_loading = 1'b0;
        chk("run_enter", {cur_creset, cur_crun, cur_busy, cur_done}, 4'b0110);
        busy_n = 1;
        done_k = -1;
        for (int k = 1; k <= 200; k++) begin
            ep  = (e != 0 && k >= e);
            clr = (k == 3);
            tick();
            clr = 1'b0;
            if (k == rst_k) begin
                #2;
                set_rst(1'b0);
                #1;
                chk_reset_vals("async_reset");
                #2;
                set_rst(1'b1);
                ep = 1'b0;
                tick();
                chk_reset_vals("after_reset");
                m_loading = 1'b1;
                m_ptr = 0;
                return;
            end
            if (k == e && !exp_to)
                chk("cnt_at_end_program", cur_cnt, e);
            if (cur_done) begin
                done_k = k;
                break;
            end
            busy_n += int'(cur_busy);
        end
        ep = 1'b0;
        chk("done_edge", done_k, exp_done);
        chk("busy_cycles", busy_n, exp_done);
        chk("final_cnt", cur_cnt, exp_cnt);
        chk("timeout", cur_to, exp_to);
        chk("done_out", {cur_creset, cur_crun, cur_busy, cur_done}, 4'b0001);
    endtask

    initial begin
        int n, e, sa;
        sel = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
        lv = 1'b0; ll = 1'b0; st = 1'b0; clr = 1'b0; ep = 1'b0; ld = '0;
        dep = 64; mx = 0; m_loading = 1'b1; m_ptr = 0;
        #12;
        chk_reset_vals("reset_a");
        #1 rst_a = 1'b1;
        tick();

        // fixed 5-word program with a gap; 6th word must stall in ARMED
        send_words(6, 4, -1, 1'b1, 1'b1);
        chk_writes();
        run_prog(12, 1'b1, -1);
        do_clear();
        send_words(3, 2, -1, 1'b0, 1'b0);
        chk_writes();
        e = $urandom_range(1, 15);
        run_prog(e, 1'b1, e + 2);

        for (int it = 0; it < 4; it++) begin
            n  = $urandom_range(1, 8);
            sa = ($urandom_range(0, 1) == 1) ? n - 1 : -1;
            send_words(n, (sa < 0) ? n - 1 : -1, sa, $urandom_range(0, 1), 1'b0);
            chk_writes();
            run_prog($urandom_range(1, 40), (sa < 0), -1);
            do_clear();
        end

        // instance B: depth 4, timeout 20
        tick();
        sel = 1'b1; dep = 4; mx = 20; m_loading = 1'b1; m_ptr = 0;
        #1;
        chk_reset_vals("reset_b");
        rst_a = 1'b0;
        rst_b = 1'b1;
        tick();
        send_words(6, -1, -1, 1'b0, 1'b0);
        chk_writes();
        run_prog(0, 1'b1, -1);
        do_clear();
        send_words(1, 0, -1, 1'b0, 1'b0);
        chk_writes();
        run_prog(20, 1'b1, -1);
        do_clear();
        send_words(2, -1, 1, 1'b0, 1'b0);
        chk_writes();
        run_prog(7, 1'b0, -1);
        do_clear();
        for (int it = 0; it < 3; it++) begin
            n = $urandom_range(1, 4);
            send_words(n, n - 1, -1, 1'b0, 1'b0);
            chk_writes();
            run_prog($urandom_range(0, 25), 1'b1, -1);
            do_clear();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
